qspi_rd_stream: RTL and testbench

- Read-side consumer stage on the QSPI clock domain.
- Accepts a byte-address read command from the QSPI slave front end and issues line requests to the SDRAM read-fill stage (qspi_rd_addr/qspi_rd_req/qspi_rd_busy).
- After each fill, reads the 8x16-bit line buffer through its read port and streams bytes to the QSPI shift-out logic over a valid/ready interface.
- Auto-advances to the next 16-byte line until the transaction is aborted (CS deassert).

---
 rtl/qspi_rd_stream.sv | 175 +++++++++++++++++
 tb/tb_qspi_rd_stream.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rd_stream.sv
// qspi_rd_stream: QSPI-domain read streamer. It requests 16-byte line fills
// and streams the line buffer out as bytes over a valid/ready handshake.
// Ports: ram_clk/rst (sync, active-high); cmd_* read command and abort;
// byte_* output stream; qspi_rd_* fill-stage request/busy; ram_* buffer read.
module qspi_rd_stream #(
    parameter int BUSY_TIMEOUT = 8,
    parameter int LINE_WORDS   = 8
) (
    input  logic        ram_clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic        cmd_abort,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic [23:0] qspi_rd_addr,
    output logic        qspi_rd_req,
    input  logic        qspi_rd_busy,
    output logic        ram_ren,
    output logic [2:0]  ram_raddr,
    input  logic [15:0] ram_rdata
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);
    localparam logic [23:0] LINE_BYTES = 24'(2 * LINE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FETCH,
        S_STREAM
    } state_t;

    state_t        state_q, state_d;
    logic          busy_m_q, busy_s_q;
    logic [23:0]   line_addr_q, line_addr_d;
    logic [2:0]    word_idx_q, word_idx_d;
    logic          byte_sel_q, byte_sel_d;
    logic [15:0]   word_reg_q, word_reg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          ren_q, ren_d;
    logic [2:0]    raddr_q, raddr_d;

    logic cmd_accept;
    logic byte_accept;

    // Abort wins over a same-cycle accept, so it also masks cmd_ready.
    assign cmd_ready = (state_q == S_IDLE) && !busy_s_q && !cmd_abort && !rst;
    assign byte_valid = (state_q == S_STREAM);
    assign byte_data = byte_sel_q ? word_reg_q[15:8] : word_reg_q[7:0];
    assign qspi_rd_addr = line_addr_q;
    assign qspi_rd_req = req_q;
    assign ram_ren = ren_q;
    assign ram_raddr = raddr_q;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign byte_accept = byte_valid && byte_ready;

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        word_idx_d  = word_idx_q;
        byte_sel_d  = byte_sel_q;
        word_reg_d  = word_reg_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        ren_d       = 1'b0;
        raddr_d     = 3'd0;
        if (cmd_abort) begin
            // An in-flight fill keeps running; IDLE waits on busy_s.
            state_d = S_IDLE;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_accept) begin
                        line_addr_d = {cmd_addr[23:1], 1'b0};
                        word_idx_d  = 3'd0;
                        byte_sel_d  = cmd_addr[0];
                        state_d     = S_REQ;
                    end
                end
                S_REQ: begin
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (busy_s_q) begin
                        req_d   = 1'b0;
                        state_d = S_WAIT_LO;
                    end else if (cnt_q == TO_LAST) begin
                        // No busy: fill stage saw a same-line hit.
                        req_d   = 1'b0;
                        ren_d   = 1'b1;
                        raddr_d = word_idx_q;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!busy_s_q) begin
                        ren_d   = 1'b1;
                        raddr_d = word_idx_q;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ren is high on the first FETCH cycle; data lands next.
                    if (!ren_q) begin
                        word_reg_d = ram_rdata;
                        state_d    = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (byte_accept) begin
                        if (!byte_sel_q) begin
                            byte_sel_d = 1'b1;
                        end else begin
                            byte_sel_d = 1'b0;
                            if (word_idx_q != LAST_WORD) begin
                                word_idx_d = word_idx_q + 3'd1;
                                ren_d      = 1'b1;
                                raddr_d    = word_idx_q + 3'd1;
                                state_d    = S_FETCH;
                            end else begin
                                line_addr_d = line_addr_q + LINE_BYTES;
                                word_idx_d  = 3'd0;
                                state_d     = S_REQ;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_m_q    <= 1'b0;
            busy_s_q    <= 1'b0;
            line_addr_q <= 24'd0;
            word_idx_q  <= 3'd0;
            byte_sel_q  <= 1'b0;
            word_reg_q  <= 16'd0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            ren_q       <= 1'b0;
            raddr_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            busy_m_q    <= qspi_rd_busy;
            busy_s_q    <= busy_m_q;
            line_addr_q <= line_addr_d;
            word_idx_q  <= word_idx_d;
            byte_sel_q  <= byte_sel_d;
            word_reg_q  <= word_reg_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            ren_q       <= ren_d;
            raddr_q     <= raddr_d;
        end
    end

endmodule

// File: tb/tb_qspi_rd_stream.sv
// tb_qspi_rd_stream: bench for qspi_rd_stream with a fill-stage model on
// its own clock, a line-buffer RAM model and a byte-address reference.
`timescale 1ns/1ps
module tb_qspi_rd_stream;

    logic        ram_clk = 1'b0;
    logic        sdram_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_addr = 24'd0;
    logic        cmd_abort = 1'b0;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic [7:0]  byte_data;
    logic [23:0] qspi_rd_addr;
    logic        qspi_rd_req;
    logic        qspi_rd_busy = 1'b0;
    logic        ram_ren;
    logic [2:0]  ram_raddr;
    logic [15:0] ram_rdata = 16'd0;

    int checks = 0;
    int errors = 0;

    always #10 ram_clk = ~ram_clk;
    always #4.5 sdram_clk = ~sdram_clk;

    qspi_rd_stream dut (
        .ram_clk      (ram_clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_abort    (cmd_abort),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .byte_data    (byte_data),
        .qspi_rd_addr (qspi_rd_addr),
        .qspi_rd_req  (qspi_rd_req),
        .qspi_rd_busy (qspi_rd_busy),
        .ram_ren      (ram_ren),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata)
    );

    // Memory contents as a function of absolute 16-bit word address.
    function automatic logic [15:0] word_of(input logic [22:0] wa);
        return {wa[15:8] ^ {1'b0, wa[22:16]} ^ 8'h11, wa[7:0] ^ 8'h80};
    endfunction

    function automatic logic [7:0] byte_of(input logic [23:0] a);
        logic [15:0] w;
        w = word_of(a[23:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // Fill stage: rising req fills 8 words from the request address and
    // holds busy 12 cycles, unless the buffer already holds that line.
    logic [15:0] mem [8];
    logic [23:0] buf_addr = 24'd0;
    logic        buf_ok = 1'b0;
    logic        sd_req_p = 1'b0;
    int          busy_left = 0;
    int          busy_rises = 0;

    always @(posedge sdram_clk) begin
        if (qspi_rd_req && !sd_req_p) begin
            if (!(buf_ok && qspi_rd_addr == buf_addr)) begin
                buf_ok = 1'b1;
                buf_addr = qspi_rd_addr;
                for (int i = 0; i < 8; i++)
                    mem[i] = word_of(qspi_rd_addr[23:1] + 23'(i));
                busy_left = 12;
                qspi_rd_busy = 1'b1;
                busy_rises++;
            end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) qspi_rd_busy = 1'b0;
        end
        sd_req_p = qspi_rd_req;
    end

    always @(posedge ram_clk)
        if (ram_ren) ram_rdata <= mem[ram_raddr];

    int   req_rises = 0;
    int   req_len = 0;
    int   last_req_len = 0;
    int   ren_cnt = 0;
    logic req_p = 1'b0;

    always @(posedge ram_clk) begin
        if (ram_ren) ren_cnt++;
        #1;
        if (qspi_rd_req && !req_p) begin
            req_rises++;
            req_len = 0;
        end
        if (qspi_rd_req) req_len++;
        else if (req_p) last_req_len = req_len;
        req_p = qspi_rd_req;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] outs();
        return {cmd_ready, byte_valid, byte_data, qspi_rd_addr,
                qspi_rd_req, ram_ren, ram_raddr};
    endfunction

    task automatic send_cmd(input logic [23:0] a);
        int g;
        g = 0;
        @(negedge ram_clk);
        cmd_valid = 1'b1;
        cmd_addr = a;
        while (!cmd_ready && g < 300) begin
            @(negedge ram_clk);
            g++;
        end
        chk("cmd_timeout", g < 300, 1);
        chk("ready_vs_busy", qspi_rd_busy, 0);
        @(negedge ram_clk);
        cmd_valid = 1'b0;
        chk("req_addr", qspi_rd_addr, {a[23:1], 1'b0});
    endtask

    task automatic stream(input logic [23:0] a0, input int n,
                          input int stall_at);
        logic [23:0] a;
        logic [7:0]  held;
        logic        rdy;
        logic        stalled;
        int got, g, r0;
        a = a0;
        got = 0;
        g = 0;
        stalled = 1'b0;
        while (got < n && g < n * 40 + 200) begin
            @(negedge ram_clk);
            g++;
            if (byte_valid && got == stall_at && !stalled) begin
                stalled = 1'b1;
                byte_ready = 1'b0;
                held = byte_data;
                r0 = ren_cnt;
                repeat (5) begin
                    @(negedge ram_clk);
                    chk("stall_valid", byte_valid, 1);
                    chk("stall_data", byte_data, held);
                end
                chk("stall_no_ren", ren_cnt - r0, 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            byte_ready = rdy;
            if (byte_valid && rdy) begin
                chk("byte", {a, byte_data}, {a, byte_of(a)});
                a++;
                got++;
            end
        end
        chk("stream_timeout", got, n);
        @(negedge ram_clk);
        byte_ready = 1'b0;
    endtask

    task automatic wait_rise(input int target);
        int g;
        g = 0;
        while (req_rises < target && g < 300) begin
            @(negedge ram_clk);
            g++;
        end
        chk("req_rise", req_rises, target);
    endtask

    task automatic wait_req_low();
        int g;
        g = 0;
        while (qspi_rd_req && g < 300) begin
            @(negedge ram_clk);
            g++;
        end
        chk("req_fall", qspi_rd_req, 0);
    endtask

    task automatic do_abort();
        @(negedge ram_clk);
        cmd_abort = 1'b1;
        @(negedge ram_clk);
        cmd_abort = 1'b0;
        chk("abort_valid", byte_valid, 0);
        chk("abort_req", qspi_rd_req, 0);
        repeat (4) @(negedge ram_clk);
    endtask

    int r0;
    int n0;
    int b0;
    logic [23:0] ra;

    initial begin
        repeat (3) @(negedge ram_clk);
        chk("rst_outs", 64'(outs()), 0);
        rst = 1'b0;
        @(negedge ram_clk);
        chk("rst_ready", cmd_ready, 1);
        chk("idle_outs", {byte_valid, qspi_rd_req, ram_ren, qspi_rd_addr}, 0);

        // Aligned start, two lines, then abort while the fill is busy.
        r0 = req_rises;
        n0 = ren_cnt;
        send_cmd(24'h000100);
        stream(24'h000100, 16, -1);
        chk("t1_one_req", req_rises - r0, 1);
        chk("t1_ren8", ren_cnt - n0, 8);
        chk("t1_next_addr", qspi_rd_addr, 24'h000110);
        wait_rise(r0 + 2);
        chk("t1_addr2", qspi_rd_addr, 24'h000110);
        stream(24'h000110, 16, -1);
        wait_rise(r0 + 3);
        wait_req_low();
        chk("wait_lo_busy", qspi_rd_busy, 1);
        cmd_abort = 1'b1;
        @(negedge ram_clk);
        cmd_abort = 1'b0;
        chk("wl_abort_valid", byte_valid, 0);
        chk("wl_abort_req", qspi_rd_req, 0);
        chk("wl_abort_ready", cmd_ready, 0);

        // Same line as buffered fill: busy never rises, timeout path.
        b0 = busy_rises;
        r0 = req_rises;
        send_cmd(24'h000121);
        wait_rise(r0 + 1);
        wait_req_low();
        chk("hit_req_len", last_req_len, 8);
        chk("hit_no_busy", busy_rises - b0, 0);
        stream(24'h000121, 15, 4);
        chk("hit_next_addr", qspi_rd_addr, 24'h000130);
        do_abort();

        // Odd start address.
        send_cmd(24'h000101);
        stream(24'h000101, 15, -1);
        chk("odd_next_addr", qspi_rd_addr, 24'h000110);
        do_abort();

        // Address wrap, then reset mid-stream.
        send_cmd(24'hFFFFF0);
        stream(24'hFFFFF0, 16, -1);
        chk("wrap_addr", qspi_rd_addr, 24'h000000);
        r0 = req_rises;
        wait_rise(r0 + 1);
        chk("wrap_req_addr", qspi_rd_addr, 24'h000000);
        stream(24'h000000, 3, -1);
        rst = 1'b1;
        @(negedge ram_clk);
        chk("mid_rst_outs", 64'(outs()), 0);
        rst = 1'b0;
        @(negedge ram_clk);
        chk("post_rst_ready", cmd_ready, 1);

        // Random commands and lengths, crossing line boundaries.
        for (int k = 0; k < 8; k++) begin
            ra = 24'($urandom);
            send_cmd(ra);
            stream(ra, $urandom_range(1, 40),
                   ($urandom_range(0, 1) == 1) ? 2 : -1);
            do_abort();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
